// File: rtl/mem_sram_banked.sv
// ============================================================================
// Module   : mem_sram_banked
// Brief    : Single-port banked SRAM with byte enables, bank-id request
//            filtering, registered reject pulse and 1- or 2-cycle read latency.
//            Optional feature macro MEM_SRAM_BANKED_INIT_EN: after reset an
//            IDLE/INIT FSM zero-fills every word, holding busy high meanwhile.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_sram_banked #(
   parameter int DATA_W  = 256,
   parameter int DEPTH   = 1024,
   parameter int ID_W    = 4,
   parameter int BANK_ID = 0,
   parameter int RD_LAT  = 1,
   localparam int BE_W   = DATA_W / 8,
   localparam int OFF_W  = $clog2(BE_W),
   localparam int IDX_W  = $clog2(DEPTH),
   localparam int ADDR_W = ID_W + IDX_W + OFF_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_cs,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [ID_W-1:0]   i_id,
   input  logic              i_read,
   input  logic              i_write,
   input  logic [DATA_W-1:0] i_data_in,
   input  logic [BE_W-1:0]   i_be,
   output logic [DATA_W-1:0] o_data_out,
   output logic              o_rd_valid,
   output logic              o_err,
   output logic              o_busy
);

   localparam logic [ID_W-1:0] c_bank_id = ID_W'(BANK_ID);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_data_out;
   logic              r_rd_valid;
   logic              r_err;

   logic              w_req;
   logic              w_accept;
   logic              w_acc_rd;
   logic              w_acc_wr;
   logic [IDX_W-1:0]  w_idx;
   logic              w_busy;
   logic              w_init_we;
   logic [IDX_W-1:0]  w_init_idx;
   logic              w_pipe_valid;
   logic [DATA_W-1:0] w_pipe_data;
   logic              w_unused_offset;

   // Offset bits select a byte inside a word; word access makes them irrelevant.
   assign w_unused_offset = &{1'b0, i_addr[OFF_W-1:0]};

   // A request needs both the requester id and the address bank field to match.
   assign w_req    = i_cs & (i_read | i_write);
   assign w_accept = w_req & ~(i_read & i_write) & ~w_busy
                   & (i_id == c_bank_id)
                   & (i_addr[ADDR_W-1 -: ID_W] == c_bank_id);
   assign w_acc_rd = w_accept & i_read;
   assign w_acc_wr = w_accept & i_write;
   assign w_idx    = i_addr[OFF_W +: IDX_W];

`ifdef MEM_SRAM_BANKED_INIT_EN
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_INIT = 1'b1;

   logic [0:0]       r_state;
   logic [0:0]       w_state_nxt;
   logic [IDX_W-1:0] r_init_idx;

   // State register; reset (re)starts the zero-fill from index 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_INIT;
         r_init_idx <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == ST_INIT) begin
            r_init_idx <= r_init_idx + IDX_W'(1);
         end
      end
   end

   // Next state: leave INIT once the last index has been cleared.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_INIT: if (r_init_idx == IDX_W'(DEPTH - 1)) w_state_nxt = ST_IDLE;
         default: w_state_nxt = r_state;
      endcase
   end

   // Outputs: busy for the whole fill; no memory writes while reset is held.
   always_comb begin
      w_busy     = (r_state == ST_INIT);
      w_init_we  = (r_state == ST_INIT) & rst_n;
      w_init_idx = r_init_idx;
   end
`else
   assign w_busy     = 1'b0;
   assign w_init_we  = 1'b0;
   assign w_init_idx = '0;
`endif

   // Storage array: not reset; zero-fill has priority over user writes.
   always_ff @(posedge clk) begin
      if (w_init_we) begin
         r_mem[w_init_idx] <= '0;
      end else if (w_acc_wr) begin
         for (int b = 0; b < BE_W; b++) begin
            if (i_be[b]) r_mem[w_idx][8*b +: 8] <= i_data_in[8*b +: 8];
         end
      end
   end

   generate
      if (RD_LAT == 2) begin : g_lat2
         logic              r_p1_valid;
         logic [DATA_W-1:0] r_p1_data;

         // Extra stage: word captured at the request edge, presented next cycle.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_p1_valid <= 1'b0;
               r_p1_data  <= '0;
            end else begin
               r_p1_valid <= w_acc_rd;
               if (w_acc_rd) r_p1_data <= r_mem[w_idx];
            end
         end

         assign w_pipe_valid = r_p1_valid;
         assign w_pipe_data  = r_p1_data;
      end else begin : g_lat1
         assign w_pipe_valid = w_acc_rd;
         assign w_pipe_data  = r_mem[w_idx];
      end
   endgenerate

   // Output stage: data only moves on a valid return, otherwise it holds.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_valid <= 1'b0;
         r_data_out <= '0;
      end else begin
         r_rd_valid <= w_pipe_valid;
         if (w_pipe_valid) r_data_out <= w_pipe_data;
      end
   end

   // Reject pulse: one cycle per refused read/write request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_err <= 1'b0;
      else        r_err <= w_req & ~w_accept;
   end

   assign o_data_out = r_data_out;
   assign o_rd_valid = r_rd_valid;
   assign o_err      = r_err;
   assign o_busy     = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_mem_sram_banked.sv
// ============================================================================
// Module   : tb_mem_sram_banked
// Brief    : Self-checking bench for mem_sram_banked. Two instances, both
//            BANK_ID=3: a default-size one with RD_LAT=1 and a small one with
//            RD_LAT=2. Expected results come from an array/queue model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_sram_banked;

   typedef struct {
      bit          v;
      logic [31:0] d;
   } ret_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n1, rst_n2;

   logic         cs1, rd1, wr1;
   logic [18:0]  addr1;
   logic [3:0]   id1;
   logic [255:0] din1, dout1;
   logic [31:0]  be1;
   logic         vld1, err1, busy1;

   logic         cs2, rd2, wr2;
   logic [9:0]   addr2;
   logic [3:0]   id2;
   logic [31:0]  din2, dout2;
   logic [3:0]   be2;
   logic         vld2, err2, busy2;

   mem_sram_banked #(.DATA_W(256), .DEPTH(1024), .ID_W(4), .BANK_ID(3), .RD_LAT(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n1), .i_cs(cs1), .i_addr(addr1), .i_id(id1),
      .i_read(rd1), .i_write(wr1), .i_data_in(din1), .i_be(be1),
      .o_data_out(dout1), .o_rd_valid(vld1), .o_err(err1), .o_busy(busy1));

   mem_sram_banked #(.DATA_W(32), .DEPTH(16), .ID_W(4), .BANK_ID(3), .RD_LAT(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n2), .i_cs(cs2), .i_addr(addr2), .i_id(id2),
      .i_read(rd2), .i_write(wr2), .i_data_in(din2), .i_be(be2),
      .o_data_out(dout2), .o_rd_valid(vld2), .o_err(err2), .o_busy(busy2));

   int           n_checks = 0;
   int           n_errors = 0;
   logic [255:0] ref1 [1024];
   logic [31:0]  ref2 [16];
   logic [255:0] exp_dout1;
   logic [31:0]  exp_dout2;
   ret_t         q2 [$];

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   function automatic logic [255:0] rand256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   // One request cycle on the RD_LAT=1 instance with model update and checks.
   task automatic cyc1(input bit cs, input bit rd, input bit wr, input logic [3:0] id,
                       input logic [18:0] addr, input logic [255:0] din, input logic [31:0] be);
      bit req, acc, ev;
      int idx;
      @(negedge clk);
      cs1 = cs; rd1 = rd; wr1 = wr; id1 = id; addr1 = addr; din1 = din; be1 = be;
      req = cs && (rd || wr);
      acc = req && !(rd && wr) && (id == 4'd3) && (addr[18:15] == 4'd3);
      idx = int'(addr[14:5]);
      ev  = acc && rd;
      if (ev) exp_dout1 = ref1[idx];
      if (acc && wr)
         for (int b = 0; b < 32; b++) if (be[b]) ref1[idx][8*b +: 8] = din[8*b +: 8];
      @(posedge clk); #1;
      chk("d1_rd_valid", {255'd0, vld1}, {255'd0, ev});
      chk("d1_err", {255'd0, err1}, {255'd0, req && !acc});
      chk("d1_data_out", dout1, exp_dout1);
      cs1 = 1'b0; rd1 = 1'b0; wr1 = 1'b0;
   endtask

   // One request cycle on the RD_LAT=2 instance; returns queued two cycles deep.
   task automatic cyc2(input bit cs, input bit rd, input bit wr, input logic [3:0] id,
                       input logic [9:0] addr, input logic [31:0] din, input logic [3:0] be);
      bit   req, acc, ev;
      int   idx;
      ret_t r;
      @(negedge clk);
      cs2 = cs; rd2 = rd; wr2 = wr; id2 = id; addr2 = addr; din2 = din; be2 = be;
      req = cs && (rd || wr);
      acc = req && !(rd && wr) && (id == 4'd3) && (addr[9:6] == 4'd3);
      idx = int'(addr[5:2]);
      ev  = acc && rd;
      q2.push_back('{v: ev, d: (ev ? ref2[idx] : 32'd0)});
      if (acc && wr)
         for (int b = 0; b < 4; b++) if (be[b]) ref2[idx][8*b +: 8] = din[8*b +: 8];
      r = q2.pop_front();
      if (r.v) exp_dout2 = r.d;
      @(posedge clk); #1;
      chk("d2_rd_valid", {255'd0, vld2}, {255'd0, r.v});
      chk("d2_err", {255'd0, err2}, {255'd0, req && !acc});
      chk("d2_data_out", {224'd0, dout2}, {224'd0, exp_dout2});
      cs2 = 1'b0; rd2 = 1'b0; wr2 = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int           op, cnt;
      logic [3:0]   rid, aid;
      logic [18:0]  a1;
      logic [9:0]   a2;
      logic [255:0] a5;

      cs1 = 0; rd1 = 0; wr1 = 0; id1 = 0; addr1 = 0; din1 = 0; be1 = 0;
      cs2 = 0; rd2 = 0; wr2 = 0; id2 = 0; addr2 = 0; din2 = 0; be2 = 0;
      rst_n1 = 1'b0; rst_n2 = 1'b0;
      for (int i = 0; i < 1024; i++) ref1[i] = '0;
      for (int i = 0; i < 16; i++)   ref2[i] = '0;
      exp_dout1 = '0; exp_dout2 = '0;
      q2.push_back('{v: 1'b0, d: 32'd0});

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_d1_valid", {255'd0, vld1}, 256'd0);
      chk("rst_d1_err",   {255'd0, err1}, 256'd0);
      chk("rst_d1_data",  dout1, 256'd0);
      chk("rst_d2_valid", {255'd0, vld2}, 256'd0);
      chk("rst_d2_err",   {255'd0, err2}, 256'd0);
      chk("rst_d2_data",  {224'd0, dout2}, 256'd0);
`ifdef MEM_SRAM_BANKED_INIT_EN
      chk("rst_d2_busy", {255'd0, busy2}, 256'd1);
      @(negedge clk);
      rst_n1 = 1'b1; rst_n2 = 1'b1;
      cs2 = 1'b1; rd2 = 1'b1; id2 = 4'd3; addr2 = {4'd3, 4'd0, 2'd0};
      @(posedge clk); #1;
      chk("d2_busy_read_err", {255'd0, err2}, 256'd1);
      chk("d2_busy_read_valid", {255'd0, vld2}, 256'd0);
      chk("d2_busy_first", {255'd0, busy2}, 256'd1);
      cs2 = 1'b0; rd2 = 1'b0;
      cnt = 1;
      while (busy2 && cnt < 100) begin
         @(posedge clk); #1;
         cnt++;
      end
      chk("d2_busy_cycles", 256'(cnt), 256'd16);
      cnt = 0;
      while (busy1 && cnt < 3000) begin
         @(posedge clk); #1;
         cnt++;
      end
      chk("d1_busy_drop", {255'd0, busy1}, 256'd0);
      for (int i = 0; i < 16; i++) cyc2(1, 1, 0, 4'd3, {4'd3, 4'(i), 2'd0}, 32'd0, 4'd0);
      cyc2(0, 0, 0, 4'd3, 10'd0, 32'd0, 4'd0);
`else
      chk("rst_d2_busy", {255'd0, busy2}, 256'd0);
      @(negedge clk);
      rst_n1 = 1'b1; rst_n2 = 1'b1;
      @(posedge clk); #1;
      chk("d1_busy_idle", {255'd0, busy1}, 256'd0);
      chk("d2_busy_idle", {255'd0, busy2}, 256'd0);
`endif

      // Full write then read-back of the same address
      a5 = {32{8'hA5}};
      cyc1(1, 0, 1, 4'd3, 19'h18040, a5, '1);
      cyc1(1, 1, 0, 4'd3, 19'h18040, '0, '0);
      chk("full_wr_rd_data", dout1, a5);

      // Single byte enable over a zeroed word
      a1 = {4'd3, 10'd9, 5'd0};
      cyc1(1, 0, 1, 4'd3, a1, '0, '1);
      cyc1(1, 0, 1, 4'd3, a1, '1, 32'h0000_0001);
      cyc1(1, 1, 0, 4'd3, a1, '0, '0);
      chk("byte0_only", dout1, {248'd0, 8'hFF});

      // Rejections: read+write, requester id, address bank field; idle cs
      cyc1(1, 1, 1, 4'd3, 19'h18040, {32{8'h5A}}, '1);
      cyc1(1, 0, 1, 4'd2, 19'h18040, {32{8'h5A}}, '1);
      cyc1(1, 0, 1, 4'd3, {4'd2, 10'd2, 5'd0}, {32{8'h5A}}, '1);
      cyc1(1, 0, 0, 4'd3, 19'h18040, '0, '0);
      cyc1(1, 1, 0, 4'd3, 19'h18040, '0, '0);
      chk("reject_no_write", dout1, a5);

      // Randomised traffic on the latency-1 instance
      for (int i = 0; i < 8; i++) cyc1(1, 0, 1, 4'd3, {4'd3, 10'(i), 5'd0}, rand256(), '1);
      for (int i = 0; i < 150; i++) begin
         op  = $urandom_range(0, 9);
         rid = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'd3;
         aid = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'd3;
         a1  = {aid, 10'($urandom_range(0, 7)), 5'($urandom_range(0, 31))};
         case (op)
            0, 1, 2, 3: cyc1(1, 1, 0, rid, a1, rand256(), $urandom);
            4, 5, 6:    cyc1(1, 0, 1, rid, a1, rand256(), $urandom);
            7:          cyc1(1, 1, 1, rid, a1, rand256(), $urandom);
            8:          cyc1(1, 0, 0, rid, a1, rand256(), $urandom);
            default:    cyc1(0, 1, 0, rid, a1, rand256(), $urandom);
         endcase
      end

      // Latency-2 instance: fill, in-order back-to-back returns
      for (int i = 0; i < 8; i++) cyc2(1, 0, 1, 4'd3, {4'd3, 4'(i), 2'd0}, $urandom, 4'hF);
      cyc2(1, 1, 0, 4'd3, {4'd3, 4'd5, 2'd0}, 32'd0, 4'd0);
      cyc2(1, 1, 0, 4'd3, {4'd3, 4'd6, 2'd0}, 32'd0, 4'd0);
      cyc2(1, 1, 0, 4'd3, {4'd3, 4'd7, 2'd0}, 32'd0, 4'd0);
      cyc2(0, 0, 0, 4'd3, 10'd0, 32'd0, 4'd0);
      cyc2(0, 0, 0, 4'd3, 10'd0, 32'd0, 4'd0);
      cyc2(0, 0, 0, 4'd3, 10'd0, 32'd0, 4'd0);
      chk("lat2_last_in_order", {224'd0, dout2}, {224'd0, ref2[7]});

      for (int i = 0; i < 80; i++) begin
         op  = $urandom_range(0, 9);
         rid = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'd3;
         a2  = {4'd3, 4'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
         case (op)
            0, 1, 2, 3, 4: cyc2(1, 1, 0, rid, a2, $urandom, 4'($urandom));
            5, 6, 7:       cyc2(1, 0, 1, rid, a2, $urandom, 4'($urandom));
            8:             cyc2(1, 1, 1, rid, a2, $urandom, 4'($urandom));
            default:       cyc2(1, 0, 0, rid, a2, $urandom, 4'($urandom));
         endcase
      end
      cyc2(0, 0, 0, 4'd3, 10'd0, 32'd0, 4'd0);

      // Reset lands while returns are in flight: no further valid strobes
      cyc2(1, 1, 0, 4'd3, {4'd3, 4'd5, 2'd0}, 32'd0, 4'd0);
      cyc2(1, 1, 0, 4'd3, {4'd3, 4'd6, 2'd0}, 32'd0, 4'd0);
      cyc2(1, 1, 0, 4'd3, {4'd3, 4'd7, 2'd0}, 32'd0, 4'd0);
      @(negedge clk);
      rst_n2 = 1'b0;
      #1;
      chk("midrst_valid", {255'd0, vld2}, 256'd0);
      chk("midrst_data",  {224'd0, dout2}, 256'd0);
      chk("midrst_err",   {255'd0, err2}, 256'd0);
      q2.delete();
      q2.push_back('{v: 1'b0, d: 32'd0});
      exp_dout2 = '0;
      @(negedge clk);
      rst_n2 = 1'b1;
`ifdef MEM_SRAM_BANKED_INIT_EN
      for (int i = 0; i < 16; i++) ref2[i] = '0;
      cnt = 0;
      while (busy2 && cnt < 100) begin
         @(posedge clk); #1;
         chk("midrst_fill_valid", {255'd0, vld2}, 256'd0);
         cnt++;
      end
      chk("d2_rebusy_cycles", 256'(cnt), 256'd16);
`endif
      for (int i = 0; i < 3; i++) cyc2(0, 0, 0, 4'd3, 10'd0, 32'd0, 4'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
